// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : Fixed-latency word-addressed data memory answering CPU loads/stores.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem_q [DEPTH];

    logic          w_access;
    logic          w_misaligned;
    logic          w_oob;
    logic          w_err;
    logic          w_commit;
    logic [AW-1:0] w_idx;

    // Any set bit above the word index means the address lies beyond DEPTH.
    assign w_misaligned = |addr_q[1:0];
    assign w_oob        = |addr_q[31:AW+2];
    assign w_err        = w_misaligned | w_oob;
    assign w_idx        = addr_q[AW+1:2];
    assign w_commit     = w_access & we_q & ~w_err;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        w_access = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = C_CNT_INIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    w_access = 1'b1;
                    ready_d  = 1'b1;
                    err_d    = w_err;
                    if (w_err) begin
                        rdata_d = 32'd0;
                    end else if (we_q) begin
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem_q[w_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge cancels the write.
    always_ff @(posedge CLK) begin
        if (RST && w_commit) begin
            mem_q[w_idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Randomized self-checking bench with a behavioural memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err, busy;

    logic        req_s, we_s;
    logic [31:0] addr_s, wdata_s;
    logic [31:0] rdata1, rdata15;
    logic        ready1, err1, busy1, ready15, err15, busy15;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m [DEPTH];
    bit          vld_m [DEPTH];

    always #5 CLK = ~CLK;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    data_mem_responder #(.DEPTH(16), .LATENCY(1)) u_lat1 (
        .CLK(CLK), .RST(RST), .req(req_s), .we(we_s), .addr(addr_s), .wdata(wdata_s),
        .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
    );

    data_mem_responder #(.DEPTH(16), .LATENCY(15)) u_lat15 (
        .CLK(CLK), .RST(RST), .req(req_s), .we(we_s), .addr(addr_s), .wdata(wdata_s),
        .rdata(rdata15), .ready(ready15), .err(err15), .busy(busy15)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // One transaction on the main DUT; optionally fires a stray store request during WAIT.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit inject, input string tag);
        int          lat;
        int          idx;
        logic [31:0] exp_rd;
        bit          e_exp;
        bit          chk_rd;
        e_exp  = exp_err(a);
        chk_rd = 1'b1;
        exp_rd = 32'd0;
        if (!e_exp) begin
            idx = int'(a >> 2);
            if (w) begin
                mem_m[idx] = d;
                vld_m[idx] = 1'b1;
                exp_rd     = d;
            end else if (vld_m[idx]) begin
                exp_rd = mem_m[idx];
            end else begin
                chk_rd = 1'b0;
            end
        end

        @(negedge CLK);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge CLK); #1;
        chk({tag, "/busy_cap"}, 32'(busy), 32'd1);
        if (inject) begin
            we = 1'b1; addr = 32'h20; wdata = 32'hBAD0BAD0;
        end else begin
            req = 1'b0;
        end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            req = 1'b0;
            if (ready) begin
                lat = k;
                chk({tag, "/err"}, 32'(err), 32'(e_exp));
                if (chk_rd) chk({tag, "/rdata"}, rdata, exp_rd);
                chk({tag, "/busy_rdy"}, 32'(busy), 32'd1);
                break;
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(LAT));
        @(posedge CLK); #1;
        chk({tag, "/ready_width"}, 32'(ready), 32'd0);
        chk({tag, "/busy_clr"}, 32'(busy), 32'd0);
        chk({tag, "/err_hold"}, 32'(err), 32'(e_exp));
        if (chk_rd) chk({tag, "/rdata_hold"}, rdata, exp_rd);
    endtask

    // Same request to the LATENCY=1 and LATENCY=15 instances; measures latency and pulse width.
    task automatic sweep(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
        int l1, l15, w1, w15;
        l1 = 0; l15 = 0; w1 = 0; w15 = 0;
        @(negedge CLK);
        req_s = 1'b1; we_s = w; addr_s = a; wdata_s = d;
        @(posedge CLK); #1;
        req_s = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (ready1) begin
                w1++;
                if (l1 == 0) l1 = k;
                chk("sweep1/rdata", rdata1, exp_rd);
            end
            if (ready15) begin
                w15++;
                if (l15 == 0) l15 = k;
                chk("sweep15/rdata", rdata15, exp_rd);
            end
        end
        chk("sweep1/latency", 32'(l1), 32'd1);
        chk("sweep15/latency", 32'(l15), 32'd15);
        chk("sweep1/width", 32'(w1), 32'd1);
        chk("sweep15/width", 32'(w15), 32'd1);
    endtask

    initial begin
        logic [31:0] a, d, v;
        logic        w;
        bit          seen;
        RST = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req_s = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0;
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset/ready", 32'(ready), 32'd0);
        chk("reset/err", 32'(err), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/rdata", rdata, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0, "fill");

        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "st10");
        txn(1'b0, 32'h10, 32'h0, 1'b0, "ld10");
        txn(1'b1, 32'h12, 32'hCAFEF00D, 1'b0, "st_misal");
        txn(1'b0, 32'h10, 32'h0, 1'b0, "ld10_again");
        txn(1'b0, 32'h100, 32'h0, 1'b0, "ld_oob");
        txn(1'b0, 32'h10, 32'h0, 1'b1, "ld_busy_ignore");
        txn(1'b0, 32'h20, 32'h0, 1'b0, "ld20_untouched");

        // Load first so rdata is non-zero, then abort a store with reset during WAIT.
        txn(1'b0, 32'h10, 32'h0, 1'b0, "ld_pre_rst");
        @(negedge CLK);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h12345678;
        @(posedge CLK); #1;
        req = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst/ready", 32'(ready), 32'd0);
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/err", 32'(err), 32'd0);
        chk("midrst/rdata", rdata, 32'd0);
        RST = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            if (ready) seen = 1'b1;
        end
        chk("midrst/no_ready", 32'(seen), 32'd0);
        txn(1'b0, 32'h8, 32'h0, 1'b0, "ld8_after_rst");

        for (int i = 0; i < 2; i++) begin
            v = $urandom;
            sweep(1'b1, 32'(i * 4), v, v);
            sweep(1'b0, 32'(i * 4), 32'h0, v);
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       a = {24'($urandom_range(0, 80)), 6'd0, 2'($urandom_range(1, 3))};
                1:       a = ($urandom_range(0, 1) != 0) ? (32'($urandom_range(64, 1000)) << 2)
                                                         : {$urandom} | 32'h8000_0000;
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            txn(w, a, d, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
